// File: rtl/vga_pkg.sv
// Shared VGA raster timing constants for the 640x480 @ 60 Hz mode and
// helpers that derive line/frame totals from the porch and sync widths.
package vga_pkg;

    localparam int unsigned COORD_W = 10;

    localparam int unsigned H_VISIBLE_DEF = 640;
    localparam int unsigned H_FRONT_DEF   = 16;
    localparam int unsigned H_SYNC_DEF    = 96;
    localparam int unsigned H_BACK_DEF    = 48;

    localparam int unsigned V_VISIBLE_DEF = 480;
    localparam int unsigned V_FRONT_DEF   = 10;
    localparam int unsigned V_SYNC_DEF    = 2;
    localparam int unsigned V_BACK_DEF    = 33;

    // A full line or frame is the visible span plus both porches and the sync pulse.
    function automatic int unsigned span_total(
        input int unsigned visible,
        input int unsigned front,
        input int unsigned sync,
        input int unsigned back
    );
        return visible + front + sync + back;
    endfunction

    localparam int unsigned H_TOTAL_DEF =
        span_total(H_VISIBLE_DEF, H_FRONT_DEF, H_SYNC_DEF, H_BACK_DEF);
    localparam int unsigned V_TOTAL_DEF =
        span_total(V_VISIBLE_DEF, V_FRONT_DEF, V_SYNC_DEF, V_BACK_DEF);

endpackage

// File: rtl/wrap_counter.sv
// Modulo counter that advances on inc and flags the step that returns it to zero.
// The next value is exported so downstream decode can register in lockstep with count.
module wrap_counter
    import vga_pkg::*;
#(
    parameter int unsigned MODULUS = H_TOTAL_DEF,
    parameter int unsigned WIDTH   = COORD_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] next,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

    assign wrap = inc && (count == LAST);

    always_comb begin
        next = count;
        if (wrap) begin
            next = '0;
        end else if (inc) begin
            next = count + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= next;
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster generator: pixel/line counters plus registered sync, blanking,
// line/frame pulses and a free-running frame counter for animation.
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_VISIBLE   = H_VISIBLE_DEF,
    parameter int unsigned H_FRONT     = H_FRONT_DEF,
    parameter int unsigned H_SYNC      = H_SYNC_DEF,
    parameter int unsigned H_BACK      = H_BACK_DEF,
    parameter int unsigned V_VISIBLE   = V_VISIBLE_DEF,
    parameter int unsigned V_FRONT     = V_FRONT_DEF,
    parameter int unsigned V_SYNC      = V_SYNC_DEF,
    parameter int unsigned V_BACK      = V_BACK_DEF,
    parameter bit          SYNC_ACTIVE = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    output logic [COORD_W-1:0] hpos,
    output logic [COORD_W-1:0] vpos,
    output logic               hsync,
    output logic               vsync,
    output logic               display_on,
    output logic               line_start,
    output logic               frame_start,
    output logic [7:0]         frame_cnt
);

    localparam int unsigned H_TOTAL = span_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int unsigned V_TOTAL = span_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

    localparam logic [COORD_W-1:0] H_VIS_END = COORD_W'(H_VISIBLE);
    localparam logic [COORD_W-1:0] V_VIS_END = COORD_W'(V_VISIBLE);
    localparam logic [COORD_W-1:0] HS_FIRST  = COORD_W'(H_VISIBLE + H_FRONT);
    localparam logic [COORD_W-1:0] HS_LAST   = COORD_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [COORD_W-1:0] VS_FIRST  = COORD_W'(V_VISIBLE + V_FRONT);
    localparam logic [COORD_W-1:0] VS_LAST   = COORD_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic [COORD_W-1:0] h_next;
    logic [COORD_W-1:0] v_next;
    logic               h_wrap;
    logic               v_wrap;

    wrap_counter #(
        .MODULUS (H_TOTAL),
        .WIDTH   (COORD_W)
    ) u_hcount (
        .clk   (clk),
        .rst   (rst),
        .inc   (1'b1),
        .count (hpos),
        .next  (h_next),
        .wrap  (h_wrap)
    );

    wrap_counter #(
        .MODULUS (V_TOTAL),
        .WIDTH   (COORD_W)
    ) u_vcount (
        .clk   (clk),
        .rst   (rst),
        .inc   (h_wrap),
        .count (vpos),
        .next  (v_next),
        .wrap  (v_wrap)
    );

    // Decoding the next-state counters keeps every flag aligned with hpos/vpos.
    always_ff @(posedge clk) begin
        if (rst) begin
            hsync       <= !SYNC_ACTIVE;
            vsync       <= !SYNC_ACTIVE;
            display_on  <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= 8'd0;
        end else begin
            hsync       <= (h_next >= HS_FIRST && h_next <= HS_LAST) ? SYNC_ACTIVE : !SYNC_ACTIVE;
            vsync       <= (v_next >= VS_FIRST && v_next <= VS_LAST) ? SYNC_ACTIVE : !SYNC_ACTIVE;
            display_on  <= (h_next < H_VIS_END) && (v_next < V_VIS_END);
            line_start  <= h_wrap;
            frame_start <= v_wrap;
            if (v_wrap) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Raster timing generator for the VGA demo designs. It produces 640x480 @ 60 Hz sync, blanking and pixel coordinates from the 25.175 MHz (25 MHz nominal) pixel clock. It sits directly upstream of the `tt_um_colorful_stripes` colour-pattern logic, which consumes `hpos`/`vpos`/`display_on` to pick RGB values and forwards `hsync`/`vsync` to the TinyVGA pins. It also provides a frame counter for animation.

## Interface
Parameters:
- `H_VISIBLE`, 640, visible pixels per line
- `H_FRONT`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, horizontal sync width (pixels)
- `H_BACK`, 48, horizontal back porch (pixels)
- `V_VISIBLE`, 480, visible lines per frame
- `V_FRONT`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BACK`, 33, vertical back porch (lines)
- `SYNC_ACTIVE`, 0, level of `hsync`/`vsync` while asserted (0 = negative polarity)

Ports:
- `clk`  in  1  pixel clock
- `rst`  in  1  synchronous, active-high reset. The top level derives it from `rst_n`.
- `hpos`  out  10  current pixel column, 0..H_TOTAL-1
- `vpos`  out  10  current line, 0..V_TOTAL-1
- `hsync`  out  1  horizontal sync at `SYNC_ACTIVE` level during the sync window
- `vsync`  out  1  vertical sync at `SYNC_ACTIVE` level during the sync window
- `display_on`  out  1  high when the current position is in the visible area
- `line_start`  out  1  one-cycle pulse on the first pixel of each line
- `frame_start`  out  1  one-cycle pulse on the first pixel of each frame
- `frame_cnt`  out  8  frame counter, increments with `frame_start`

## Operation
- H_TOTAL = sum of the H parameters (800). V_TOTAL = sum of the V parameters (525).
- `hpos` increments every cycle and wraps from H_TOTAL-1 to 0.
- `vpos` increments only when `hpos` wraps. It wraps from V_TOTAL-1 to 0 on the same cycle that `hpos` wraps.
- Horizontal sync window: `hpos` in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1], which is [656,751].
- Vertical sync window: `vpos` in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1], which is [490,491].
- `display_on` = (`hpos` < H_VISIBLE) && (`vpos` < V_VISIBLE).
- `line_start` is asserted on a cycle where `hpos` becomes 0 by wrap.
- `frame_start` is asserted on a cycle where `hpos` and `vpos` both become 0 by wrap.
- `frame_cnt` increments on the same edge that produces `frame_start` and is visible on the `frame_start` cycle. It wraps 255 -> 0.
- Reset values while `rst` is high: `hpos`=0, `vpos`=0, `hsync`=`vsync`=!SYNC_ACTIVE, `display_on`=0, `line_start`=0, `frame_start`=0, `frame_cnt`=0.
- Reset applied mid-frame overrides all counting on the next edge; there is no partial-frame completion.

## Timing
- All outputs are registered. The decoded outputs (`hsync`, `vsync`, `display_on`, pulses) are computed from the next-state counters, so every output is cycle-aligned with the `hpos`/`vpos` value presented in the same cycle. There is no pipeline skew.
- First cycle after reset release: `hpos`=1, `vpos`=0, `display_on`=1.
- Pixel (0,0) of the first frame after reset is therefore blanked, and no `line_start`/`frame_start` pulse is issued for it.
- The first `frame_start` occurs 420000 cycles after the first cycle with `rst` low, and then every 420000 cycles.
- `line_start` repeats every 800 cycles.
- Simultaneous wrap of `hpos` and `vpos` asserts `line_start` and `frame_start` in the same cycle.

## Structure
- Shared package `vga_pkg` holds:
  - the default 640x480 timing constants;
  - the H_TOTAL/V_TOTAL derivations;
  - the coordinate width constant (10).
- The H and V derivations are used by the stripe generator and any future pattern blocks.
- One sub-module is natural: `wrap_counter` (parameterised modulus and width, `inc` input, `wrap` output). It is instantiated twice; the horizontal instance's `wrap` drives the vertical instance's `inc`.
- The sync/blank decode and the frame counter live in `vga_sync_gen`.

## Test plan
- Assert `rst` for 3 cycles, then release -> during reset all outputs hold their reset values; on the first cycle after release `hpos`=1, `vpos`=0, `display_on`=1, `hsync`=`vsync`=1.
- Run one line -> `hsync`=0 exactly for `hpos` 656..751 (96 cycles); `display_on` falls when `hpos` goes 639->640; `line_start` fires when `hpos` goes 799->0 with `vpos`=1.
- Run one full frame -> `vsync` low exactly for `vpos` 490..491 (1600 cycles). `frame_start` and `line_start` are both high when the position goes (799,524)->(0,0), `frame_cnt` reads 1 on that cycle, and the period is 420000 cycles.
- Run 256 frames -> `frame_cnt` wraps 255->0 on the 256th `frame_start`.
- Assert `rst` for 1 cycle at (700,300), inside the hsync window -> on the next cycle all outputs show reset values (`hsync`=1, `hpos`=0, `vpos`=0), and counting restarts from `hpos`=1.
- Override parameters with a tiny mode (H 8/2/2/2, V 4/1/1/1) -> 14x7-cycle frame; sync and blank windows follow the same formulas.
